// File: rtl/esc_pwm_out.sv
// esc_pwm_out
// Four-channel ESC pulse generator fed by the motor mixer. Each signed
// command is clamped to 0..MAX_CMD and turned into a servo-style pulse of
// MIN_US + cmd microseconds, repeated every FRAME_US microseconds. An arming
// FSM holds every channel at MIN_US until arming is requested and the
// commanded throttle has been held at zero for ARM_FRAMES frames.
//
// All per-frame state (widths, saturation flags, FSM transitions) updates
// only on the frame latch cycle, so a pulse in flight is never reshaped by
// mixer activity. The only exception is disarming, which takes effect on the
// very next clock edge; even then the pulse in progress runs to its latched
// width and only the following frame drops back to MIN_US.
module esc_pwm_out #(
    parameter int CLK_PER_US = 50,
    parameter int FRAME_US   = 2500,
    parameter int MIN_US     = 1000,
    parameter int MAX_CMD    = 1000,
    parameter int ARM_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic signed [15:0] m1,
    input  logic signed [15:0] m2,
    input  logic signed [15:0] m3,
    input  logic signed [15:0] m4,
    output logic [3:0]         pwm_out,
    output logic               armed,
    output logic               frame_start,
    output logic [3:0]         sat
);

    // ------------------------------------------------------------------
    // Widths of the counters and latched values, sized from their maxima.
    // ------------------------------------------------------------------
    localparam int PC_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int FC_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    // Widths never exceed MIN_US + MAX_CMD, which is below FRAME_US, so a
    // width always fits in the frame counter's width.
    localparam int W_W   = $clog2(MIN_US + MAX_CMD + 1);
    localparam int CMD_W = $clog2(MAX_CMD + 1);
    localparam int ZC_W  = $clog2(ARM_FRAMES + 1);

    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(CLK_PER_US - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_US - 1);
    localparam logic [ZC_W-1:0]   ZC_LAST   = ZC_W'(ARM_FRAMES - 1);
    localparam logic [W_W-1:0]    MIN_W     = W_W'(MIN_US);
    localparam logic [CMD_W-1:0]  MAX_CMD_U = CMD_W'(MAX_CMD);
    localparam logic signed [16:0] MAX_CMD_S = 17'(MAX_CMD);

    typedef enum logic [1:0] {
        DISARMED  = 2'd0,
        ARM_CHECK = 2'd1,
        ARMED     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_reg;
    logic [FC_W-1:0] fc_reg;
    logic            us_tick;
    logic            latch;

    assign us_tick = (pc_reg == PC_LAST);
    // The latch cycle is the last clock of the last microsecond of a frame.
    assign latch   = us_tick && (fc_reg == FC_LAST);

    // Microsecond prescaler: counts clocks within one microsecond.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= '0;
        end else if (us_tick) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_reg + PC_W'(1);
        end
    end

    // Frame counter in microseconds, wrapping at the end of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_reg <= '0;
        end else if (us_tick) begin
            if (fc_reg == FC_LAST) begin
                fc_reg <= '0;
            end else begin
                fc_reg <= fc_reg + FC_W'(1);
            end
        end
    end

    // One-cycle marker in the first cycle of each new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch;
        end
    end

    // ------------------------------------------------------------------
    // Arming FSM
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [ZC_W-1:0] zc_reg;
    logic            armed_reg;
    logic [3:0]      cmd_zero;
    logic            all_zero;
    logic            armed_after_latch;

    assign all_zero = (cmd_zero == 4'b1111);

    // Whether the FSM will be ARMED once the transition at the latch cycle
    // has been taken; the width registers use this to pick armed widths in
    // the same frame that arming completes.
    assign armed_after_latch =
        ((state_reg == ARM_CHECK) && arm && all_zero && (zc_reg == ZC_LAST)) ||
        ((state_reg == ARMED) && arm);

    // Arming state machine: transitions at the latch cycle, except that
    // dropping arm while ARMED disarms on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DISARMED;
            zc_reg    <= '0;
            armed_reg <= 1'b0;
        end else if ((state_reg == ARMED) && !arm) begin
            state_reg <= DISARMED;
            armed_reg <= 1'b0;
        end else if (latch) begin
            case (state_reg)
                DISARMED: begin
                    if (arm) begin
                        state_reg <= ARM_CHECK;
                        zc_reg    <= '0;
                    end
                end
                ARM_CHECK: begin
                    if (!arm) begin
                        state_reg <= DISARMED;
                    end else if (all_zero) begin
                        zc_reg <= zc_reg + ZC_W'(1);
                        if (zc_reg == ZC_LAST) begin
                            state_reg <= ARMED;
                            armed_reg <= 1'b1;
                        end
                    end else begin
                        zc_reg <= '0;
                    end
                end
                ARMED: begin
                    // arm is high here; nothing changes until it drops.
                    state_reg <= ARMED;
                end
                default: begin
                    state_reg <= DISARMED;
                    armed_reg <= 1'b0;
                end
            endcase
        end
    end

    assign armed = armed_reg;

    // ------------------------------------------------------------------
    // Per-channel clamp, width latch and pulse output
    // ------------------------------------------------------------------
    logic signed [15:0] m_in [4];

    assign m_in[0] = m1;
    assign m_in[1] = m2;
    assign m_in[2] = m3;
    assign m_in[3] = m4;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic signed [16:0] m_ext;
            logic [CMD_W-1:0]   cmd;
            logic               clamped;
            logic [W_W-1:0]     w_reg;
            logic               sat_reg;
            logic               pwm_reg;

            // Sign-extend to 17 bits so the comparison against MAX_CMD
            // cannot overflow for any 16-bit input.
            assign m_ext = {m_in[gi][15], m_in[gi]};

            // Clamp the mixer command into 0..MAX_CMD and flag clamping.
            always_comb begin
                cmd     = '0;
                clamped = 1'b0;
                if (m_ext < 17'sd0) begin
                    cmd     = '0;
                    clamped = 1'b1;
                end else if (m_ext > MAX_CMD_S) begin
                    cmd     = MAX_CMD_U;
                    clamped = 1'b1;
                end else begin
                    cmd     = CMD_W'(m_ext);
                    clamped = 1'b0;
                end
            end

            assign cmd_zero[gi] = (cmd == '0);

            // Latch the pulse width and clamp flag once per frame.
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_reg   <= '0;
                    sat_reg <= 1'b0;
                end else if (latch) begin
                    sat_reg <= clamped;
                    if (armed_after_latch) begin
                        w_reg <= MIN_W + W_W'(cmd);
                    end else begin
                        w_reg <= MIN_W;
                    end
                end
            end

            // Registered pulse: high while the frame position is below the
            // latched width, giving exactly w * CLK_PER_US high cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pwm_reg <= 1'b0;
                end else begin
                    pwm_reg <= (fc_reg < FC_W'(w_reg));
                end
            end

            assign pwm_out[gi] = pwm_reg;
            assign sat[gi]     = sat_reg;
        end
    endgenerate

endmodule
